// File: rtl/parking_duration_tracker.sv
`timescale 1ns/1ps
// Multi-slot parking duration tracker: free-running time base, per-slot entry timestamps,
// elapsed-time results on a valid/ready port. Define DURATION_SAT_EN to saturate long stays.
module parking_duration_tracker #(
   parameter int WIDTH    = 8,
   parameter int SLOTS    = 4,
   parameter int TICK_DIV = 1,
   localparam int SW      = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   input  logic             cmd_exit,
   input  logic [SW-1:0]    cmd_slot,
   output logic             cmd_ready,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             res_err,
   output logic [SW-1:0]    res_slot,
   output logic [WIDTH-1:0] res_dur,
   output logic [WIDTH-1:0] now,
   output logic [SLOTS-1:0] occupied
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [WIDTH-1:0] DUR_MAX    = '1;

   logic [PW-1:0]    presc_q, presc_d;
   logic [WIDTH-1:0] now_q, now_d;
   logic [SLOTS-1:0] occ_q, occ_d;
   logic [WIDTH-1:0] ts_q [SLOTS];
   logic [WIDTH-1:0] ts_d [SLOTS];
   logic             res_valid_q, res_valid_d;
   logic             res_err_q, res_err_d;
   logic [SW-1:0]    res_slot_q, res_slot_d;
   logic [WIDTH-1:0] res_dur_q, res_dur_d;
`ifdef DURATION_SAT_EN
   logic [SLOTS-1:0] sat_q, sat_d;
   logic             sel_sat;
`endif

   logic             tick;
   logic             accept;
   logic             in_range;
   logic             sel_occ;
   logic [WIDTH-1:0] sel_ts;
   logic [WIDTH-1:0] sel_dur;
   logic             do_enter;
   logic             do_exit;
   logic             load_res;
   logic             new_err;
   logic [WIDTH-1:0] new_dur;

   assign cmd_ready = !res_valid_q || res_ready;
   assign accept    = cmd_valid && cmd_ready;
   assign in_range  = int'(cmd_slot) < SLOTS;

   always_comb begin
      tick    = (presc_q == PRESC_LAST);
      presc_d = tick ? '0 : presc_q + 1'b1;
      now_d   = tick ? now_q + 1'b1 : now_q;
   end

   // Slot lookup via compare loop so out-of-range codes never index the arrays.
   always_comb begin
      sel_occ = 1'b0;
      sel_ts  = '0;
`ifdef DURATION_SAT_EN
      sel_sat = 1'b0;
`endif
      for (int i = 0; i < SLOTS; i++) begin
         if (cmd_slot == SW'(i)) begin
            sel_occ = occ_q[i];
            sel_ts  = ts_q[i];
`ifdef DURATION_SAT_EN
            sel_sat = sat_q[i];
`endif
         end
      end
      sel_dur = now_q + ~sel_ts + 1'b1;
`ifdef DURATION_SAT_EN
      if (sel_sat) begin
         sel_dur = DUR_MAX;
      end
`endif
   end

   always_comb begin
      do_enter = 1'b0;
      do_exit  = 1'b0;
      load_res = 1'b0;
      new_err  = 1'b1;
      new_dur  = '0;
      if (accept) begin
         load_res = 1'b1;
         if (in_range && !cmd_exit && !sel_occ) begin
            do_enter = 1'b1;
            load_res = 1'b0;
         end else if (in_range && cmd_exit && sel_occ) begin
            do_exit = 1'b1;
            new_err = 1'b0;
            new_dur = sel_dur;
         end
      end
   end

   always_comb begin
      occ_d       = occ_q;
      ts_d        = ts_q;
      res_valid_d = res_valid_q;
      res_err_d   = res_err_q;
      res_slot_d  = res_slot_q;
      res_dur_d   = res_dur_q;
`ifdef DURATION_SAT_EN
      sat_d = sat_q;
      for (int i = 0; i < SLOTS; i++) begin
         if (tick && occ_q[i] && ((now_q + ~ts_q[i] + 1'b1) == DUR_MAX)) begin
            sat_d[i] = 1'b1;
         end
      end
`endif
      // Command updates come after the saturation scan so enter/exit clears win.
      for (int i = 0; i < SLOTS; i++) begin
         if (cmd_slot == SW'(i)) begin
            if (do_enter) begin
               occ_d[i] = 1'b1;
               ts_d[i]  = now_q;
`ifdef DURATION_SAT_EN
               sat_d[i] = 1'b0;
`endif
            end
            if (do_exit) begin
               occ_d[i] = 1'b0;
`ifdef DURATION_SAT_EN
               sat_d[i] = 1'b0;
`endif
            end
         end
      end
      if (res_valid_q && res_ready) begin
         res_valid_d = 1'b0;
      end
      if (load_res) begin
         res_valid_d = 1'b1;
         res_err_d   = new_err;
         res_slot_d  = cmd_slot;
         res_dur_d   = new_dur;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         presc_q     <= '0;
         now_q       <= '0;
         occ_q       <= '0;
         res_valid_q <= 1'b0;
         res_err_q   <= 1'b0;
         res_slot_q  <= '0;
         res_dur_q   <= '0;
         for (int i = 0; i < SLOTS; i++) begin
            ts_q[i] <= '0;
         end
`ifdef DURATION_SAT_EN
         sat_q <= '0;
`endif
      end else begin
         presc_q     <= presc_d;
         now_q       <= now_d;
         occ_q       <= occ_d;
         ts_q        <= ts_d;
         res_valid_q <= res_valid_d;
         res_err_q   <= res_err_d;
         res_slot_q  <= res_slot_d;
         res_dur_q   <= res_dur_d;
`ifdef DURATION_SAT_EN
         sat_q <= sat_d;
`endif
      end
   end

   assign res_valid = res_valid_q;
   assign res_err   = res_err_q;
   assign res_slot  = res_slot_q;
   assign res_dur   = res_dur_q;
   assign now       = now_q;
   assign occupied  = occ_q;

endmodule

// File: tb/tb_parking_duration_tracker.sv
`timescale 1ns/1ps
// Bench for parking_duration_tracker: absolute-time scoreboard checked every cycle,
// plus directed scenarios with literal expectations; second instance covers TICK_DIV=3, SLOTS=3.
module tb_parking_duration_tracker;
   localparam int WIDTH = 8;
   localparam int SLOTS = 4;
   localparam int SW    = 2;
   localparam int MASK  = (1 << WIDTH) - 1;

   logic             clk = 1'b0;
   logic             reset;
   logic             cmd_valid, cmd_exit, res_ready;
   logic [SW-1:0]    cmd_slot;
   logic             cmd_ready, res_valid, res_err;
   logic [SW-1:0]    res_slot;
   logic [WIDTH-1:0] res_dur, now;
   logic [SLOTS-1:0] occupied;

   logic             b_valid, b_exit, b_ready;
   logic [1:0]       b_slot;
   logic             b_cmd_ready, b_res_valid, b_res_err;
   logic [1:0]       b_res_slot;
   logic [WIDTH-1:0] b_res_dur, b_now;
   logic [2:0]       b_occupied;

   int total = 0;
   int bad   = 0;
   bit chk_en = 0;

   int m_time, m_presc;
   bit m_occ [SLOTS];
   int m_ts  [SLOTS];
   bit m_res_valid, m_res_err;
   int m_res_slot, m_res_dur;

   parking_duration_tracker #(.WIDTH(WIDTH), .SLOTS(SLOTS), .TICK_DIV(1)) dut (
      .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_exit(cmd_exit),
      .cmd_slot(cmd_slot), .cmd_ready(cmd_ready), .res_valid(res_valid),
      .res_ready(res_ready), .res_err(res_err), .res_slot(res_slot),
      .res_dur(res_dur), .now(now), .occupied(occupied));

   parking_duration_tracker #(.WIDTH(WIDTH), .SLOTS(3), .TICK_DIV(3)) dut_b (
      .clk(clk), .reset(reset), .cmd_valid(b_valid), .cmd_exit(b_exit),
      .cmd_slot(b_slot), .cmd_ready(b_cmd_ready), .res_valid(b_res_valid),
      .res_ready(b_ready), .res_err(b_res_err), .res_slot(b_res_slot),
      .res_dur(b_res_dur), .now(b_now), .occupied(b_occupied));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [SLOTS-1:0] m_occ_vec();
      logic [SLOTS-1:0] v;
      for (int i = 0; i < SLOTS; i++) v[i] = m_occ[i];
      return v;
   endfunction

   task automatic m_result(input bit err, input int slot, input int dur);
      m_res_valid = 1;
      m_res_err   = err;
      m_res_slot  = slot;
      m_res_dur   = dur;
   endtask

   // Called just after a rising edge, while the inputs sampled at that edge are still applied.
   task automatic model_update();
      bit rdy;
      int s, el;
      if (reset) begin
         m_time = 0; m_presc = 0;
         for (int i = 0; i < SLOTS; i++) begin m_occ[i] = 0; m_ts[i] = 0; end
         m_res_valid = 0; m_res_err = 0; m_res_slot = 0; m_res_dur = 0;
         return;
      end
      rdy = !m_res_valid || res_ready;
      if (m_res_valid && res_ready) m_res_valid = 0;
      if (cmd_valid && rdy) begin
         s = int'(cmd_slot);
         if (s >= SLOTS) m_result(1, s, 0);
         else if (!cmd_exit) begin
            if (m_occ[s]) m_result(1, s, 0);
            else begin m_occ[s] = 1; m_ts[s] = m_time; end
         end else begin
            if (!m_occ[s]) m_result(1, s, 0);
            else begin
               el = m_time - m_ts[s];
`ifdef DURATION_SAT_EN
               m_result(0, s, (el > MASK) ? MASK : el);
`else
               m_result(0, s, el & MASK);
`endif
               m_occ[s] = 0;
            end
         end
      end
      m_presc++;
      if (m_presc == 1) begin m_presc = 0; m_time++; end
   endtask

   task automatic step(input bit v, input bit ex, input int s, input bit rdy, input bit rst);
      cmd_valid = v; cmd_exit = ex; cmd_slot = SW'(s); res_ready = rdy; reset = rst;
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 1, 0);
   endtask

   task automatic wait_now(input int t);
      int guard = 0;
      while (((m_time & MASK) != t) && guard < 1000) begin
         idle(1);
         guard++;
      end
      if (guard >= 1000) chk("wait_now_timeout", 32'd0, 32'd1);
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         chk("now", 32'(now), 32'(m_time & MASK));
         chk("occupied", 32'(occupied), 32'(m_occ_vec()));
         chk("cmd_ready", 32'(cmd_ready), 32'(!m_res_valid || res_ready));
         chk("res_valid", 32'(res_valid), 32'(m_res_valid));
         if (m_res_valid) begin
            chk("res_err", 32'(res_err), 32'(m_res_err));
            chk("res_slot", 32'(res_slot), 32'(m_res_slot));
            chk("res_dur", 32'(res_dur), 32'(m_res_dur));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      b_valid = 0; b_exit = 0; b_slot = '0; b_ready = 1;
      step(0, 0, 0, 1, 1);
      step(0, 0, 0, 1, 1);
      chk_en = 1;
      chk("rst_now", 32'(now), 32'd0);
      chk("rst_occ", 32'(occupied), 32'd0);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_res_err", 32'(res_err), 32'd0);
      chk("rst_res_slot", 32'(res_slot), 32'd0);
      chk("rst_res_dur", 32'(res_dur), 32'd0);
      chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);

      // enter slot 2 at now=5, exit at now=20
      wait_now(5);
      step(1, 0, 2, 1, 0);
      wait_now(20);
      step(1, 1, 2, 1, 0);
      chk("basic_valid", 32'(res_valid), 32'd1);
      chk("basic_dur", 32'(res_dur), 32'd15);
      chk("basic_err", 32'(res_err), 32'd0);
      chk("basic_slot", 32'(res_slot), 32'd2);
      chk("basic_occ2", 32'(occupied[2]), 32'd0);

      // wrapped time base
      wait_now(250);
      step(1, 0, 1, 1, 0);
      wait_now(4);
      step(1, 1, 1, 1, 0);
      chk("wrap_dur", 32'(res_dur), 32'd10);
      chk("wrap_err", 32'(res_err), 32'd0);

      // error responses
      step(1, 1, 3, 1, 0);
      chk("exit_free_err", 32'(res_err), 32'd1);
      chk("exit_free_dur", 32'(res_dur), 32'd0);
      chk("exit_free_slot", 32'(res_slot), 32'd3);
      chk("exit_free_occ", 32'(occupied), 32'd0);
      step(1, 0, 0, 1, 0);
      step(1, 0, 0, 1, 0);
      chk("dup_enter_err", 32'(res_err), 32'd1);
      chk("dup_enter_dur", 32'(res_dur), 32'd0);
      chk("dup_enter_slot", 32'(res_slot), 32'd0);
      chk("dup_enter_occ", 32'(occupied), 32'd1);
      step(1, 1, 0, 1, 0);
      chk("dup_exit_dur", 32'(res_dur), 32'd2);

      // backpressure: result held, commands blocked until handshake
      step(1, 0, 2, 1, 0);
      step(1, 1, 2, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 0, 0);
         chk("hold_valid", 32'(res_valid), 32'd1);
         chk("hold_ready", 32'(cmd_ready), 32'd0);
         chk("hold_dur", 32'(res_dur), 32'd1);
      end
      step(1, 0, 3, 0, 0);
      chk("blocked_occ3", 32'(occupied[3]), 32'd0);
      step(1, 0, 3, 1, 0);
      chk("handshake_enter_valid", 32'(res_valid), 32'd0);
      chk("handshake_enter_occ3", 32'(occupied[3]), 32'd1);
      step(1, 1, 3, 0, 0);
      chk("exit3_dur", 32'(res_dur), 32'd1);
      step(1, 1, 1, 1, 0);
      chk("reload_valid", 32'(res_valid), 32'd1);
      chk("reload_err", 32'(res_err), 32'd1);
      chk("reload_slot", 32'(res_slot), 32'd1);

      // back-to-back exits at full throughput
      for (int i = 0; i < 3; i++) step(1, 0, i, 1, 0);
      for (int i = 0; i < 3; i++) begin
         step(1, 1, i, 1, 0);
         chk("b2b_slot", 32'(res_slot), 32'(i));
         chk("b2b_dur", 32'(res_dur), 32'd3);
      end

      // long stay: 300 ticks
      wait_now(0);
      step(1, 0, 0, 1, 0);
      idle(299);
      step(1, 1, 0, 1, 0);
`ifdef DURATION_SAT_EN
      chk("long_dur", 32'(res_dur), 32'd255);
`else
      chk("long_dur", 32'(res_dur), 32'd44);
`endif

      // reset with a pending result and occupied slots; command during reset ignored
      step(1, 0, 2, 1, 0);
      step(1, 0, 1, 1, 0);
      step(1, 1, 1, 0, 0);
      step(1, 0, 0, 0, 1);
      chk("mid_rst_valid", 32'(res_valid), 32'd0);
      chk("mid_rst_occ", 32'(occupied), 32'd0);
      chk("mid_rst_now", 32'(now), 32'd0);
      chk("b_rst_now", 32'(b_now), 32'd0);

      // TICK_DIV=3 instance: enter, exit nine cycles later
      b_valid = 1; b_exit = 0; b_slot = 2'd0;
      idle(1);
      b_valid = 0;
      idle(8);
      b_valid = 1; b_exit = 1; b_slot = 2'd0;
      idle(1);
      b_valid = 0;
      chk("div3_valid", 32'(b_res_valid), 32'd1);
      chk("div3_dur", 32'(b_res_dur), 32'd3);
      chk("div3_err", 32'(b_res_err), 32'd0);
      b_valid = 1; b_exit = 0; b_slot = 2'd3;
      idle(1);
      b_valid = 0;
      chk("oor_err", 32'(b_res_err), 32'd1);
      chk("oor_slot", 32'(b_res_slot), 32'd3);
      chk("oor_dur", 32'(b_res_dur), 32'd0);
      chk("oor_occ", 32'(b_occupied), 32'd0);

      idle(2);
      chk_en = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
